// File: rtl/pipe_mem_pkg.sv
// Shared encodings for the memory-access stage: load kinds and access FSM states.
package pipe_mem_pkg;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects byte/halfword by address low bits and extends to 32 bits.
module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  ld_op_i,
  output logic [31:0] result_o
);
  import pipe_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Unknown encodings fall through to a full-word load.
    case (ld_op_i)
      LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result_o = {24'd0, byte_sel};
      LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pipe_mem.sv
// Memory-access pipeline stage: latches EX results, runs one split-handshake SRAM access,
// aligns load data and drives write-back and decode-bypass information.
module pipe_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        from_valid,
  input  logic        from_allowin,
  input  logic [31:0] from_pc,
  input  logic [31:0] alu_result_EX,
  input  logic        rf_we_EX,
  input  logic [4:0]  rf_waddr_EX,
  input  logic        res_from_mem_EX,
  input  logic        data_sram_en_EX,
  input  logic [3:0]  data_sram_we_EX,
  input  logic [31:0] data_sram_wdata_EX,
  input  logic [2:0]  ld_op_EX,
  output logic        to_valid,
  output logic        to_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] PC,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
  output logic        fwd_stall
);
  import pipe_mem_pkg::*;

  mem_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, alu_q, wdata_q, rdata_q;
  logic        rf_we_q, res_from_mem_q, en_q;
  logic [4:0]  waddr_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  ld_op_q;
  logic        ready_go, data_allowin;
  logic [31:0] load_data;

  assign ready_go     = !en_q || (state_q == DONE);
  assign to_allowin   = !valid_q || (ready_go && from_allowin);
  assign to_valid     = valid_q && ready_go;
  assign data_allowin = from_valid && to_allowin;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (to_allowin) begin
      valid_d = from_valid;
      state_d = (from_valid && data_sram_en_EX) ? REQ : IDLE;
    end else begin
      // data_ok while still in REQ belongs to no request of ours and is ignored.
      case (state_q)
        REQ:     if (data_sram_addr_ok) state_d = WAIT;
        WAIT:    if (data_sram_data_ok) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= '0;
      alu_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      rf_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      en_q           <= 1'b0;
      waddr_q        <= '0;
      wstrb_q        <= '0;
      ld_op_q        <= '0;
    end else begin
      if (data_allowin) begin
        pc_q           <= from_pc;
        alu_q          <= alu_result_EX;
        wdata_q        <= data_sram_wdata_EX;
        rf_we_q        <= rf_we_EX;
        res_from_mem_q <= res_from_mem_EX;
        en_q           <= data_sram_en_EX;
        waddr_q        <= rf_waddr_EX;
        wstrb_q        <= data_sram_we_EX;
        ld_op_q        <= ld_op_EX;
      end
      if (valid_q && (state_q == WAIT) && data_sram_data_ok) begin
        rdata_q <= data_sram_rdata;
      end
    end
  end

  mem_load_align u_align (
    .rdata_i   (rdata_q),
    .addr_lo_i (alu_q[1:0]),
    .ld_op_i   (ld_op_q),
    .result_o  (load_data)
  );

  assign data_sram_req   = valid_q && (state_q == REQ);
  assign data_sram_wr    = |wstrb_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = alu_q;
  assign data_sram_wdata = wdata_q;

  assign PC        = pc_q;
  assign rf_we     = valid_q && rf_we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = res_from_mem_q ? load_data : alu_q;
  assign fwd_we    = valid_q && rf_we_q;
  assign fwd_waddr = waddr_q;
  assign fwd_wdata = rf_wdata;
  assign fwd_stall = valid_q && res_from_mem_q && (state_q != DONE);

endmodule

// File: doc/pipe_mem.md
# pipe_mem

Memory-access stage of the five-stage in-order pipeline, directly downstream of the execute stage and upstream of write-back. Latches the execute result and memory controls on the valid/allowin handshake, issues at most one request on a split-handshake data SRAM port (req/addr_ok, then data_ok), and aligns and extends load data. Produces the final register write value for write-back, plus bypass/stall information for the decode stage.

## Interface
Parameters: none. Widths are fixed at 32-bit data/address and 5-bit register index.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- from_valid  in  1  execute stage has a valid instruction to hand over
- from_allowin  in  1  write-back stage can accept
- from_pc  in  32  PC of incoming instruction
- alu_result_EX  in  32  execute result; memory address for loads/stores
- rf_we_EX, rf_waddr_EX[4:0], res_from_mem_EX  in  register-write controls
- data_sram_en_EX  in  1  instruction accesses memory
- data_sram_we_EX  in  4  byte strobes, already lane-aligned; nonzero = store
- data_sram_wdata_EX  in  32  store data, already lane-replicated
- ld_op_EX  in  3  load kind: 0 W, 1 B, 2 H, 3 BU, 4 HU
- to_valid  out  1  valid instruction offered to write-back
- to_allowin  out  1  this stage accepts from execute
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  4  byte strobes
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  request accepted this cycle
- data_sram_data_ok  in  1  read data or write ack this cycle
- data_sram_rdata  in  32  read data, valid with data_ok
- PC  out  32  PC of held instruction
- rf_we, rf_waddr[4:0], rf_wdata[31:0]  out  write-back controls/value
- fwd_we, fwd_waddr[4:0], fwd_wdata[31:0]  out  bypass to decode
- fwd_stall  out  1  decode must stall a consumer of fwd_waddr

## Operation
- valid register; ready_go = !mem_access || state==DONE; to_allowin = !valid || (ready_go && from_allowin); to_valid = valid && ready_go.
- On data_allowin (from_valid && to_allowin): all EX inputs latched; state <= data_sram_en_EX ? REQ : IDLE. On to_allowin without from_valid: valid <= 0, state <= IDLE.
- FSM: IDLE (no access); REQ: data_sram_req=1, go WAIT on addr_ok; WAIT: on data_ok capture rdata, go DONE; DONE: hold until handover.
- data_sram_addr = latched alu_result; wr = |wstrb; wstrb/wdata from latched values; req only in REQ with valid=1.
- Load align by addr[1:0]: B/BU pick byte, H/HU pick halfword at addr[1]; B/H sign-extend, BU/HU zero-extend; W passes through.
- rf_wdata = res_from_mem ? aligned load data : alu_result; rf_we output gated by valid.
- fwd_we = valid && rf_we; fwd_wdata = rf_wdata; fwd_stall = valid && res_from_mem && state!=DONE.
- Unaligned addresses are not checked here.

## Timing
- Reset: valid 0, state IDLE, PC/rf_waddr/rf_wdata/latched data 0, all req/we outputs 0; mid-transaction reset abandons the access.
- Non-memory instruction: enters cycle N, to_valid in N.
- Access with addr_ok in N and data_ok in N+1: DONE and to_valid in N+2. Each extra cycle of addr_ok or data_ok delay adds one cycle.
- addr_ok and data_ok are never both expected in the same cycle for one request; data_ok in REQ is ignored.
- DONE with from_allowin=0: hold all outputs; the next instruction may enter in the same cycle the current one leaves.

## Structure
- Shared package: ld_op encodings (LD_W..LD_HU) and FSM state encoding (IDLE, REQ, WAIT, DONE).
- One combinational sub-module, mem_load_align: rdata, addr[1:0], ld_op -> 32-bit result.

## Test plan
- Non-memory ADD result 0x12345678, rf_waddr 5, from_allowin=1 -> to_valid the same cycle, rf_wdata 0x12345678, fwd_stall 0.
- LD_B at addr 0x1003, rdata 0x80FF_0000, zero-wait SRAM -> rf_wdata 0xFFFF_FF80 two cycles after entry; LD_BU -> 0x0000_0080.
- LD_HU at 0x1002, rdata 0xBEEF_1234 -> 0x0000_BEEF. Hold addr_ok low 3 cycles -> req held, fwd_stall 1 throughout, latency +3.
- Store wstrb 0011 at 0x2000, data 0xAAAA5555 -> req/wr=1, wstrb 0011. Store completes on data_ok; rf_we 0.
- Load in DONE with from_allowin=0 for 4 cycles -> outputs stable, to_allowin 0. Release -> next instruction latched in the same cycle.
- Assert reset while in WAIT -> valid 0, req 0 immediately. A late data_ok is ignored.
